// File: rtl/flush_recovery_ctrl.sv
// rtl/flush_recovery_ctrl.sv - rename-state recovery sequencer: RRF to RAT copy and free-list rebuild
module flush_recovery_ctrl #(
    parameter  int NUM_REGS       = 64,
    parameter  int COPY_PER_CYCLE = 4,
    localparam int PHYS_W         = $clog2(NUM_REGS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush_req,
    input  logic [31:0][PHYS_W-1:0]                rrf_map,
    output logic                                   stall_commit,
    output logic                                   stall_rename,
    output logic                                   busy,
    output logic                                   rat_wr_en,
    output logic [4:0]                             rat_wr_base,
    output logic [COPY_PER_CYCLE-1:0][PHYS_W-1:0]  rat_wr_data,
    output logic                                   fl_clear,
    output logic                                   fl_push_valid,
    output logic [PHYS_W-1:0]                      fl_push_preg,
    output logic                                   flush_done,
    output logic                                   map_err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DRAIN = 3'd1;
    localparam logic [2:0] COPY  = 3'd2;
    localparam logic [2:0] SCAN  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [4:0]        LAST_BASE = 5'(32 - COPY_PER_CYCLE);
    localparam logic [4:0]        BASE_STEP = 5'(COPY_PER_CYCLE);
    localparam logic [PHYS_W-1:0] LAST_IDX  = PHYS_W'(NUM_REGS - 1);

    logic [2:0]                            state;
    logic [4:0]                            copy_base;
    logic [PHYS_W-1:0]                     scan_idx;
    logic [NUM_REGS-1:0]                   occupied;
    logic [COPY_PER_CYCLE-1:0][PHYS_W-1:0] group_data;
    logic [NUM_REGS-1:0]                   set_mask;
    logic                                  dup;
    logic                                  in_copy;
    logic                                  in_scan;
    logic                                  accept;

    assign in_copy = (state == COPY);
    assign in_scan = (state == SCAN);
    assign accept  = (state == IDLE) && flush_req;

    // Gather the current group from the RRF and flag any preg already claimed or repeated within the group
    always_comb begin
        group_data = '0;
        set_mask   = '0;
        dup        = 1'b0;
        for (int k = 0; k < COPY_PER_CYCLE; k++) begin
            group_data[k] = rrf_map[copy_base + 5'(k)];
            if (occupied[group_data[k]] || set_mask[group_data[k]]) begin
                dup = 1'b1;
            end
            set_mask[group_data[k]] = 1'b1;
        end
    end

    // Stall is gated by reset so every output reads 0 while rst_n is low
    assign busy          = (state != IDLE);
    assign stall_commit  = rst_n & (flush_req | busy);
    assign stall_rename  = rst_n & (flush_req | busy);
    assign rat_wr_en     = in_copy;
    assign rat_wr_base   = in_copy ? copy_base : 5'd0;
    assign rat_wr_data   = in_copy ? group_data : '0;
    assign fl_clear      = (state == DRAIN);
    assign fl_push_valid = in_scan & ~occupied[scan_idx];
    assign fl_push_preg  = in_scan ? scan_idx : '0;
    assign flush_done    = (state == DONE);

    // Sequencer: IDLE -> DRAIN -> COPY groups -> SCAN all pregs -> DONE; flush_req ignored outside IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            copy_base <= '0;
            scan_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state     <= DRAIN;
                        copy_base <= '0;
                    end
                end
                DRAIN: state <= COPY;
                COPY: begin
                    if (copy_base == LAST_BASE) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                    end else begin
                        copy_base <= copy_base + BASE_STEP;
                    end
                end
                SCAN: begin
                    if (scan_idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Occupied bitmap and sticky duplicate-mapping flag; both restart on an accepted flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupied <= '0;
            map_err  <= 1'b0;
        end else if (accept) begin
            occupied <= '0;
            map_err  <= 1'b0;
        end else if (in_copy) begin
            occupied <= occupied | set_mask;
            if (dup) begin
                map_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flush_recovery_ctrl.sv
// tb/tb_flush_recovery_ctrl.sv - directed scoreboard bench for flush_recovery_ctrl
module tb_flush_recovery_ctrl;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_req;
    logic [31:0][5:0] rrf_map;
    logic             stall_commit;
    logic             stall_rename;
    logic             busy;
    logic             rat_wr_en;
    logic [4:0]       rat_wr_base;
    logic [3:0][5:0]  rat_wr_data;
    logic             fl_clear;
    logic             fl_push_valid;
    logic [5:0]       fl_push_preg;
    logic             flush_done;
    logic             map_err;

    int tests = 0;
    int fails = 0;

    logic [28:0] ratq[$];
    logic [5:0]  pushq[$];

    flush_recovery_ctrl #(.NUM_REGS(64), .COPY_PER_CYCLE(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_req     (flush_req),
        .rrf_map       (rrf_map),
        .stall_commit  (stall_commit),
        .stall_rename  (stall_rename),
        .busy          (busy),
        .rat_wr_en     (rat_wr_en),
        .rat_wr_base   (rat_wr_base),
        .rat_wr_data   (rat_wr_data),
        .fl_clear      (fl_clear),
        .fl_push_valid (fl_push_valid),
        .fl_push_preg  (fl_push_preg),
        .flush_done    (flush_done),
        .map_err       (map_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        return |{stall_commit, stall_rename, busy, rat_wr_en, rat_wr_base, rat_wr_data,
                 fl_clear, fl_push_valid, fl_push_preg, flush_done, map_err};
    endfunction

    task automatic set_identity();
        for (int i = 0; i < 32; i++) rrf_map[i] = 6'(i);
    endtask

    // pulse_cyc: cycle in which a spurious flush_req is raised; rst_cyc: cycle in which reset hits;
    // err_cyc: first cycle map_err must read 1 (0 = never). Cycle 0 is the flush_req cycle.
    task automatic run_flush(input int pulse_cyc, input int rst_cyc, input int err_cyc);
        bit          used[64];
        int          done_cnt = 0;
        int          pushes   = 0;
        int          exp_pushes;
        logic [28:0] rq;
        logic [5:0]  pq;
        ratq.delete();
        pushq.delete();
        for (int b = 0; b < 32; b += 4)
            ratq.push_back({5'(b), rrf_map[b+3], rrf_map[b+2], rrf_map[b+1], rrf_map[b]});
        for (int p = 0; p < 64; p++) used[p] = 1'b0;
        for (int i = 0; i < 32; i++) used[rrf_map[i]] = 1'b1;
        for (int p = 0; p < 64; p++) if (!used[p]) pushq.push_back(6'(p));
        exp_pushes = pushq.size();

        @(negedge clk);
        flush_req = 1'b1;
        #1;
        chk("stall_same_cycle", {30'd0, stall_commit, stall_rename}, 32'd3);
        @(negedge clk);
        flush_req = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            chk("map_err", map_err, (err_cyc != 0 && cyc >= err_cyc));
            if (cyc == 1) chk("drain_fl_clear", fl_clear, 1);
            if (cyc == 75) chk("idle_after_done", busy, 0);
            if (rat_wr_en) begin
                if (ratq.size() == 0) begin
                    chk("rat_unexpected", rat_wr_en, 0);
                end else begin
                    rq = ratq.pop_front();
                    chk("rat_base", rat_wr_base, rq[28:24]);
                    chk("rat_data", rat_wr_data, rq[23:0]);
                end
            end
            if (fl_push_valid) begin
                pushes++;
                if (pushq.size() == 0) begin
                    chk("push_unexpected", fl_push_valid, 0);
                end else begin
                    pq = pushq.pop_front();
                    chk("push_preg", fl_push_preg, pq);
                end
            end
            if (flush_done) begin
                done_cnt++;
                chk("done_latency", cyc, 74);
            end
            flush_req = (cyc == pulse_cyc);
            if (cyc == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("reset_mid_outputs", any_out(), 0);
                return;
            end
            @(negedge clk);
        end
        chk("done_count", done_cnt, 1);
        chk("push_count", pushes, exp_pushes);
        chk("rat_leftover", ratq.size(), 0);
        chk("push_leftover", pushq.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush_req = 1'b1;
        set_identity();
        repeat (3) @(negedge clk);
        chk("reset_outputs", any_out(), 0);
        flush_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", any_out(), 0);

        // identity mapping: pushes 32..63
        run_flush(0, 0, 0);

        // permuted mapping: x1->p40, x5->p63
        rrf_map[1] = 6'd40;
        rrf_map[5] = 6'd63;
        run_flush(0, 0, 0);

        // duplicate: x3 and x7 -> p50; x7 sits in group base 4 (cycle 3), flag visible from cycle 4
        set_identity();
        rrf_map[3] = 6'd50;
        rrf_map[7] = 6'd50;
        run_flush(0, 0, 4);
        repeat (2) @(negedge clk);
        chk("map_err_held", map_err, 1);

        // spurious flush_req at SCAN index 10 (cycle 20); also clears map_err on acceptance
        set_identity();
        run_flush(20, 0, 0);

        // reset at SCAN index 20 (cycle 30)
        run_flush(0, 30, 0);
        @(negedge clk);
        chk("reset_hold_outputs", any_out(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_abort", busy, 0);
        run_flush(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
